// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Self-test front end for the 4-bit ALU. The host loads a short program of
//   {exp, op, b, a} entries, then pulses start. Each entry is driven onto the
//   ALU command inputs and held there. After SETTLE cycles the ALU's registered
//   result is compared against exp. Pass/fail status, the failure count, the
//   index of the first failure and the last flags seen are held until the next
//   accepted start.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   prog_we_i/addr/data   program entry write (only while idle)
//   prog_len_i            entries to run, clamped to DEPTH, sampled at start
//   start_i               run request
//   alu_a/b/op_o          command to the ALU, held from issue through check
//   alu_result_i          ALU output {Z,N,V,C,result[3:0]}
//   busy_o, done_o        run in progress / one-cycle end-of-run pulse
//   pass_o, fail_count_o  result of the last completed run
//   first_fail_idx_o      index of the first failing entry (0 if none)
//   last_flags_o          alu_result_i[7:4] at the most recent check
//
// state  | meaning
// IDLE   | waiting for start, program writes accepted
// ISSUE  | command registered onto alu_*
// WAIT   | SETTLE-cycle down-count for ALU latency
// CHECK  | compare result, capture flags, step to next entry
// FINISH | end-of-run cycle, then back to IDLE
module alu_cmd_sequencer #(
    parameter int DEPTH  = 8,
    parameter int SETTLE = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          prog_we_i,
    input  logic [AW-1:0] prog_addr_i,
    input  logic [15:0]   prog_data_i,
    input  logic [4:0]    prog_len_i,
    input  logic          start_i,
    output logic [3:0]    alu_a_o,
    output logic [3:0]    alu_b_o,
    output logic [3:0]    alu_op_o,
    input  logic [7:0]    alu_result_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          pass_o,
    output logic [4:0]    fail_count_o,
    output logic [AW-1:0] first_fail_idx_o,
    output logic [3:0]    last_flags_o
);

    localparam int CW = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);
    localparam logic [3:0] OP_REG_WRITE = 4'b1000;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_FINISH} state_t;

    state_t        state_q;
    logic [15:0]   mem_q [DEPTH];
    logic [4:0]    len_q;
    logic [AW-1:0] idx_q;
    logic [CW-1:0] wait_q;
    logic [3:0]    alu_a_q, alu_b_q, alu_op_q;
    logic          busy_q, done_q, pass_q;
    logic [4:0]    fail_cnt_q;
    logic [AW-1:0] first_fail_q;
    logic [3:0]    flags_q;

    logic [4:0]    len_d;
    logic [4:0]    fail_cnt_d;
    logic [AW-1:0] idx_d;
    logic          mismatch;
    logic          last_entry;

    always_comb begin
        len_d      = (prog_len_i > DEPTH_L) ? DEPTH_L : prog_len_i;
        idx_d      = idx_q + AW'(1);
        last_entry = (5'(idx_q) == (len_q - 5'd1));
        // REG_WRITE produces no meaningful result, so it never counts as a failure.
        mismatch   = (alu_op_q != OP_REG_WRITE) && (alu_result_i[3:0] != mem_q[idx_q][15:12]);
        fail_cnt_d = fail_cnt_q;
        if (mismatch && (fail_cnt_q != 5'd31)) begin
            fail_cnt_d = fail_cnt_q + 5'd1;
        end
    end

    // Program memory is deliberately left out of reset so a test program
    // survives an aborted run.
    always_ff @(posedge clk_i) begin
        if (prog_we_i && (state_q == S_IDLE)) begin
            mem_q[prog_addr_i] <= prog_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            wait_q       <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
            flags_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        len_q        <= len_d;
                        idx_q        <= '0;
                        busy_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        fail_cnt_q   <= '0;
                        first_fail_q <= '0;
                        flags_q      <= '0;
                        if (len_d != 5'd0) begin
                            alu_a_q  <= mem_q[0][3:0];
                            alu_b_q  <= mem_q[0][7:4];
                            alu_op_q <= mem_q[0][11:8];
                            state_q  <= S_ISSUE;
                        end else begin
                            state_q  <= S_FINISH;
                        end
                    end
                end
                S_ISSUE: begin
                    wait_q  <= CW'(SETTLE - 1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_q == '0) begin
                        state_q <= S_CHECK;
                    end else begin
                        wait_q <= wait_q - CW'(1);
                    end
                end
                S_CHECK: begin
                    flags_q    <= alu_result_i[7:4];
                    fail_cnt_q <= fail_cnt_d;
                    if (mismatch && (fail_cnt_q == 5'd0)) begin
                        first_fail_q <= idx_q;
                    end
                    if (last_entry) begin
                        // done is raised here so it is visible during FINISH.
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_cnt_d == 5'd0);
                        state_q <= S_FINISH;
                    end else begin
                        idx_q    <= idx_d;
                        alu_a_q  <= mem_q[idx_d][3:0];
                        alu_b_q  <= mem_q[idx_d][7:4];
                        alu_op_q <= mem_q[idx_d][11:8];
                        state_q  <= S_ISSUE;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                    if (done_q) begin
                        done_q <= 1'b0;
                    end else begin
                        // Empty run arrived straight from IDLE: report a trivial pass now.
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_a_o          = alu_a_q;
    assign alu_b_o          = alu_b_q;
    assign alu_op_o         = alu_op_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign fail_count_o     = fail_cnt_q;
    assign first_fail_idx_o = first_fail_q;
    assign last_flags_o     = flags_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [2:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic [4:0]  prog_len = '0;
    logic        start = 1'b0;
    logic [3:0]  alu_a, alu_b, alu_op;
    logic [7:0]  alu_result = '0;
    logic        busy, done, pass;
    logic [4:0]  fail_count;
    logic [2:0]  first_fail_idx;
    logic [3:0]  last_flags;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(8), .SETTLE(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_data_i(prog_data),
        .prog_len_i(prog_len), .start_i(start),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .alu_result_i(alu_result),
        .busy_o(busy), .done_o(done), .pass_o(pass),
        .fail_count_o(fail_count), .first_fail_idx_o(first_fail_idx),
        .last_flags_o(last_flags)
    );

    // Behavioural 4-bit ALU with a 16-entry register file and one output register.
    // Opcodes: 0 ADD, 1 SUB, 8 REG_WRITE (reg[b]=a), 9 REG_READ, A ADD_REG, B SUB_REG.
    logic [3:0] regs [16];
    initial for (int i = 0; i < 16; i++) regs[i] = 4'd0;

    function automatic logic [7:0] alu_eval(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] op, input logic [3:0] rv);
        logic [4:0] s;
        logic       v;
        s = 5'd0;
        v = 1'b0;
        case (op)
            4'h0: begin s = {1'b0, a} + {1'b0, b};           v = (a[3] == b[3])  && (s[3] != a[3]); end
            4'h1: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1;   v = (a[3] != b[3])  && (s[3] != a[3]); end
            4'h8: s = {1'b0, a};
            4'h9: s = {1'b0, rv};
            4'hA: begin s = {1'b0, a} + {1'b0, rv};          v = (a[3] == rv[3]) && (s[3] != a[3]); end
            4'hB: begin s = {1'b0, a} + {1'b0, ~rv} + 5'd1;  v = (a[3] != rv[3]) && (s[3] != a[3]); end
            default: s = 5'd0;
        endcase
        return {(s[3:0] == 4'd0), s[3], v, s[4], s[3:0]};
    endfunction

    always @(posedge clk) begin
        alu_result <= alu_eval(alu_a, alu_b, alu_op, regs[alu_b]);
        if (alu_op == 4'h8) regs[alu_b] <= alu_a;
    end

    task automatic write_entry(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = addr; prog_data = data;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Starts a run and observes it. k counts negedges, k = cycle after posedge k
    // where posedge 0 is the edge that accepts start. At k == disturb_at a start
    // request and a write to entry 0 are injected for one cycle.
    task automatic run_prog(input logic [4:0] len, input int disturb_at,
                            output int busy_n, output int done_n, output int done_cyc);
        busy_n = 0; done_n = 0; done_cyc = -1;
        @(negedge clk);
        prog_len = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 120; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = k;
            end
            if ((done_cyc >= 0) && (k > done_cyc + 2)) break;
            if (k == disturb_at) begin
                start = 1'b1; prog_len = 5'd5;
                prog_we = 1'b1; prog_addr = 3'd0; prog_data = 16'hF000;
            end else begin
                start = 1'b0; prog_we = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; prog_we = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL reset_busy: got %0d want 0", busy); end
        checks++; if (done !== 1'b0)           begin errors++; $display("FAIL reset_done: got %0d want 0", done); end
        checks++; if (pass !== 1'b0)           begin errors++; $display("FAIL reset_pass: got %0d want 0", pass); end
        checks++; if (fail_count !== 5'd0)     begin errors++; $display("FAIL reset_fail_count: got %0d want 0", fail_count); end
        checks++; if (first_fail_idx !== 3'd0) begin errors++; $display("FAIL reset_first_fail: got %0d want 0", first_fail_idx); end
        checks++; if (last_flags !== 4'd0)     begin errors++; $display("FAIL reset_flags: got %0h want 0", last_flags); end
        checks++; if ({alu_a, alu_b, alu_op} !== 12'h000) begin errors++; $display("FAIL reset_alu_cmd: got %0h want 000", {alu_a, alu_b, alu_op}); end
        rst = 1'b0;
    endtask

    task automatic load_program();
        write_entry(3'd0, 16'h0837); // REG_WRITE a=7 b=3
        write_entry(3'd1, 16'h7930); // REG_READ  b=3        exp 7
        write_entry(3'd2, 16'h9A32); // ADD_REG   a=2 b=3    exp 9
        write_entry(3'd3, 16'hBB32); // SUB_REG   a=2 b=3    exp B
        write_entry(3'd4, 16'h8053); // ADD       a=3 b=5    exp 8, V set
        write_entry(3'd5, 16'h3012); // ADD       a=2 b=1    exp 3
        write_entry(3'd6, 16'h8044); // ADD       a=4 b=4    exp 8
        write_entry(3'd7, 16'h7129); // SUB       a=9 b=2    exp 7, flags V,C
    endtask

    task automatic test_pass_run();
        int bn, dn, dc;
        run_prog(5'd5, -1, bn, dn, dc);
        checks++; if (bn !== 20)             begin errors++; $display("FAIL pass_busy_cycles: got %0d want 20", bn); end
        checks++; if (dn !== 1)              begin errors++; $display("FAIL pass_done_pulses: got %0d want 1", dn); end
        checks++; if (dc !== 20)             begin errors++; $display("FAIL pass_done_cycle: got %0d want 20", dc); end
        checks++; if (pass !== 1'b1)         begin errors++; $display("FAIL pass_pass: got %0d want 1", pass); end
        checks++; if (fail_count !== 5'd0)   begin errors++; $display("FAIL pass_fail_count: got %0d want 0", fail_count); end
        checks++; if (last_flags !== 4'b0110) begin errors++; $display("FAIL pass_flags: got %b want 0110", last_flags); end
    endtask

    task automatic test_fault_run();
        int bn, dn, dc;
        write_entry(3'd2, 16'h8A32);
        run_prog(5'd5, -1, bn, dn, dc);
        checks++; if (dc !== 20)               begin errors++; $display("FAIL fault_done_cycle: got %0d want 20", dc); end
        checks++; if (pass !== 1'b0)           begin errors++; $display("FAIL fault_pass: got %0d want 0", pass); end
        checks++; if (fail_count !== 5'd1)     begin errors++; $display("FAIL fault_fail_count: got %0d want 1", fail_count); end
        checks++; if (first_fail_idx !== 3'd2) begin errors++; $display("FAIL fault_first_idx: got %0d want 2", first_fail_idx); end
        checks++; if (last_flags !== 4'b0110)  begin errors++; $display("FAIL fault_flags: got %b want 0110", last_flags); end
        write_entry(3'd2, 16'h9A32);
    endtask

    task automatic test_len_zero();
        int bn, dn, dc;
        run_prog(5'd0, -1, bn, dn, dc);
        // done is seen in the cycle after posedge 1: two cycles after the start cycle.
        checks++; if (dc !== 1)              begin errors++; $display("FAIL zero_done_cycle: got %0d want 1", dc); end
        checks++; if (dn !== 1)              begin errors++; $display("FAIL zero_done_pulses: got %0d want 1", dn); end
        checks++; if (pass !== 1'b1)         begin errors++; $display("FAIL zero_pass: got %0d want 1", pass); end
        checks++; if (fail_count !== 5'd0)   begin errors++; $display("FAIL zero_fail_count: got %0d want 0", fail_count); end
        checks++; if ({alu_a, alu_b, alu_op} !== 12'h350) begin errors++; $display("FAIL zero_alu_hold: got %0h want 350", {alu_a, alu_b, alu_op}); end
    endtask

    task automatic test_len_clamp();
        int bn, dn, dc;
        run_prog(5'd12, -1, bn, dn, dc);
        checks++; if (dc !== 32)              begin errors++; $display("FAIL clamp_done_cycle: got %0d want 32", dc); end
        checks++; if (bn !== 32)              begin errors++; $display("FAIL clamp_busy_cycles: got %0d want 32", bn); end
        checks++; if (pass !== 1'b1)          begin errors++; $display("FAIL clamp_pass: got %0d want 1", pass); end
        checks++; if ({alu_a, alu_b, alu_op} !== 12'h921) begin errors++; $display("FAIL clamp_last_cmd: got %0h want 921", {alu_a, alu_b, alu_op}); end
        checks++; if (last_flags !== 4'b0011) begin errors++; $display("FAIL clamp_flags: got %b want 0011", last_flags); end
    endtask

    task automatic test_busy_ignore();
        int bn, dn, dc;
        run_prog(5'd3, 5, bn, dn, dc);
        checks++; if (dc !== 12)      begin errors++; $display("FAIL ignore_done_cycle: got %0d want 12", dc); end
        checks++; if (dn !== 1)       begin errors++; $display("FAIL ignore_done_pulses: got %0d want 1", dn); end
        checks++; if (pass !== 1'b1)  begin errors++; $display("FAIL ignore_pass: got %0d want 1", pass); end
        run_prog(5'd1, -1, bn, dn, dc);
        checks++; if ({alu_a, alu_b, alu_op} !== 12'h738) begin errors++; $display("FAIL ignore_entry0: got %0h want 738", {alu_a, alu_b, alu_op}); end
        checks++; if (dc !== 4)       begin errors++; $display("FAIL ignore_len1_done: got %0d want 4", dc); end
    endtask

    task automatic test_reset_mid_run();
        int bn, dn, dc;
        int done_seen;
        write_entry(3'd2, 16'h8A32);
        @(negedge clk);
        prog_len = 5'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk); // k = 13: first WAIT cycle of entry 3
        checks++; if (fail_count !== 5'd1) begin errors++; $display("FAIL midrst_pre_fail_count: got %0d want 1", fail_count); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL midrst_busy: got %0d want 0", busy); end
        checks++; if (fail_count !== 5'd0)     begin errors++; $display("FAIL midrst_fail_count: got %0d want 0", fail_count); end
        checks++; if (first_fail_idx !== 3'd0) begin errors++; $display("FAIL midrst_first_idx: got %0d want 0", first_fail_idx); end
        checks++; if (last_flags !== 4'd0)     begin errors++; $display("FAIL midrst_flags: got %b want 0000", last_flags); end
        checks++; if ({alu_a, alu_b, alu_op} !== 12'h000) begin errors++; $display("FAIL midrst_alu_cmd: got %0h want 000", {alu_a, alu_b, alu_op}); end
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b0;
            if (done) done_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d want 0", done_seen); end
        run_prog(5'd5, -1, bn, dn, dc);
        checks++; if (dc !== 20)               begin errors++; $display("FAIL rerun_done_cycle: got %0d want 20", dc); end
        checks++; if (fail_count !== 5'd1)     begin errors++; $display("FAIL rerun_fail_count: got %0d want 1", fail_count); end
        checks++; if (first_fail_idx !== 3'd2) begin errors++; $display("FAIL rerun_first_idx: got %0d want 2", first_fail_idx); end
        checks++; if (pass !== 1'b0)           begin errors++; $display("FAIL rerun_pass: got %0d want 0", pass); end
    endtask

    initial begin
        test_reset();
        load_program();
        test_pass_run();
        test_fault_run();
        test_len_zero();
        test_len_clamp();
        test_busy_ignore();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
